// File: rtl/mwc_pkg.sv
// Shared types for the memory-write checker: FSM state and failure cause encodings.
package mwc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'd0,
    FC_ADDR    = 2'd1,
    FC_DATA    = 2'd2,
    FC_TIMEOUT = 2'd3
  } fail_code_e;

endpackage

// File: rtl/mwc_entry_match.sv
// Parallel compare of one monitored write against every expected-write entry.
// Hits are qualified by en_i so the caller decides which entries are eligible.
module mwc_entry_match #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic [DEPTH-1:0][ADDR_W-1:0] exp_addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0] exp_data_i,
  input  logic [DEPTH-1:0]             en_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DATA_W-1:0]            data_i,
  output logic [DEPTH-1:0]             addr_hit_o,
  output logic [DEPTH-1:0]             full_hit_o
);

  always_comb begin
    addr_hit_o = '0;
    full_hit_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      addr_hit_o[i] = en_i[i] && (exp_addr_i[i] == addr_i);
      full_hit_o[i] = en_i[i] && (exp_addr_i[i] == addr_i) && (exp_data_i[i] == data_i);
    end
  end

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the data-memory write port against a programmed table of (address, data) pairs.
// Optional MWC_OUT_OF_ORDER_EN accepts the expected writes in any order via a seen mask.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 4,
  parameter int IGN_LO         = 80,
  parameter int IGN_HI         = 80,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_we,
  input  logic [$clog2(DEPTH)-1:0]             cfg_idx,
  input  logic [ADDR_W-1:0]                    cfg_addr,
  input  logic [DATA_W-1:0]                    cfg_data,
  input  logic [$clog2(DEPTH+1)-1:0]           cfg_num,
  input  logic                                 start,
  input  logic                                 memwrite,
  input  logic [ADDR_W-1:0]                    dataadr,
  input  logic [DATA_W-1:0]                    writedata,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 pass,
  output logic [1:0]                           fail_code,
  output logic [$clog2(DEPTH+1)-1:0]           match_count,
  output logic [ADDR_W-1:0]                    fail_addr,
  output logic [DATA_W-1:0]                    fail_data,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0]  cycle_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [ADDR_W-1:0] IGN_LO_A = ADDR_W'(IGN_LO);
  localparam logic [ADDR_W-1:0] IGN_HI_A = ADDR_W'(IGN_HI);

  state_e                      state_q;
  fail_code_e                  fail_code_q;
  logic [CW-1:0]               num_q;
  logic [CW-1:0]               match_count_q;
  logic [TW-1:0]               cycle_count_q;
  logic [ADDR_W-1:0]           fail_addr_q;
  logic [DATA_W-1:0]           fail_data_q;
  logic [DEPTH-1:0][ADDR_W-1:0] exp_addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] exp_data_q;

  logic [DEPTH-1:0] cmp_en;
  logic [DEPTH-1:0] addr_hit;
  logic [DEPTH-1:0] full_hit;
  logic [CW-1:0]    num_clamped;
  logic             any_full, any_addr, in_ign, timeout_hit, last_match;

`ifdef MWC_OUT_OF_ORDER_EN
  logic [DEPTH-1:0] seen_q;
  logic [DEPTH-1:0] valid_mask;
  logic [DEPTH-1:0] pick;

  // Eligible entries are the valid ones not yet seen; the lowest-index full hit is consumed.
  always_comb begin
    valid_mask = '0;
    for (int i = 0; i < DEPTH; i++) valid_mask[i] = (CW'(i) < num_q);
    cmp_en = valid_mask & ~seen_q;
    pick = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (full_hit[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end
`else
  always_comb begin
    cmp_en = '0;
    if (match_count_q < num_q) cmp_en = DEPTH'(1) << match_count_q;
  end
`endif

  mwc_entry_match #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_match (
    .exp_addr_i(exp_addr_q),
    .exp_data_i(exp_data_q),
    .en_i      (cmp_en),
    .addr_i    (dataadr),
    .data_i    (writedata),
    .addr_hit_o(addr_hit),
    .full_hit_o(full_hit)
  );

  always_comb begin
    num_clamped = (cfg_num > CW'(DEPTH)) ? CW'(DEPTH) : cfg_num;
    any_full    = |full_hit;
    any_addr    = |addr_hit;
    in_ign      = (dataadr >= IGN_LO_A) && (dataadr <= IGN_HI_A);
    timeout_hit = (cycle_count_q == TW'(TIMEOUT_CYCLES - 1));
    last_match  = ((match_count_q + CW'(1)) == num_q);
  end

  // A failing write takes precedence over a timeout landing on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      num_q         <= '0;
      match_count_q <= '0;
      cycle_count_q <= '0;
      fail_code_q   <= FC_NONE;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
`ifdef MWC_OUT_OF_ORDER_EN
      seen_q        <= '0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (cycle_count_q != TW'(TIMEOUT_CYCLES)) cycle_count_q <= cycle_count_q + TW'(1);
          if (memwrite && any_full) begin
            match_count_q <= match_count_q + CW'(1);
`ifdef MWC_OUT_OF_ORDER_EN
            seen_q <= seen_q | pick;
`endif
            if (last_match) begin
              state_q <= PASS;
            end else if (timeout_hit) begin
              state_q     <= FAIL;
              fail_code_q <= FC_TIMEOUT;
            end
          end else if (memwrite && any_addr) begin
            state_q     <= FAIL;
            fail_code_q <= FC_DATA;
            fail_addr_q <= dataadr;
            fail_data_q <= writedata;
          end else if (memwrite && !in_ign) begin
            state_q     <= FAIL;
            fail_code_q <= FC_ADDR;
            fail_addr_q <= dataadr;
            fail_data_q <= writedata;
          end else if (timeout_hit) begin
            state_q     <= FAIL;
            fail_code_q <= FC_TIMEOUT;
            fail_addr_q <= '0;
            fail_data_q <= '0;
          end
        end
        default: begin
          if (start) begin
            num_q         <= num_clamped;
            match_count_q <= '0;
            cycle_count_q <= '0;
            fail_code_q   <= FC_NONE;
            fail_addr_q   <= '0;
            fail_data_q   <= '0;
`ifdef MWC_OUT_OF_ORDER_EN
            seen_q        <= '0;
`endif
            state_q       <= (num_clamped == '0) ? PASS : RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_addr_q <= '0;
      exp_data_q <= '0;
    end else if (cfg_we && (state_q != RUN)) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cfg_idx == IW'(i)) begin
          exp_addr_q[i] <= cfg_addr;
          exp_data_q[i] <= cfg_data;
        end
      end
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == PASS) || (state_q == FAIL);
  assign pass        = (state_q == PASS);
  assign fail_code   = fail_code_q;
  assign match_count = match_count_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker with hand-computed expectations (TIMEOUT_CYCLES=20).
module tb_mem_write_checker;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TMO    = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_idx = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic [2:0]        cfg_num = '0;
  logic              start = 1'b0;
  logic              memwrite = 1'b0;
  logic [ADDR_W-1:0] dataadr = '0;
  logic [DATA_W-1:0] writedata = '0;
  logic              busy, done, pass;
  logic [1:0]        fail_code;
  logic [2:0]        match_count;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic [4:0]        cycle_count;

  int checks = 0;
  int errors = 0;

  mem_write_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .IGN_LO(80), .IGN_HI(80), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_num(cfg_num), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
    .match_count(match_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .cycle_count(cycle_count)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked on the falling edge before new drives.
  task automatic cfg_entry(input int idx, input int a, input int d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_addr = ADDR_W'(a); cfg_data = DATA_W'(d);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input int num);
    @(negedge clk);
    cfg_num = 3'(num); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_write(input int a, input int d);
    memwrite = 1'b1; dataadr = ADDR_W'(a); writedata = DATA_W'(d);
    @(negedge clk);
    memwrite = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_code", fail_code, 0);
    check("rst_cycles", cycle_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // 1: scratch write tolerated, then matching write passes
    cfg_entry(0, 84, 7);
    start_run(1);
    check("t1_busy", busy, 1);
    check("t1_cyc0", cycle_count, 0);
    do_write(80, 3);
    check("t1_ign_busy", busy, 1);
    check("t1_ign_mc", match_count, 0);
    check("t1_ign_cyc", cycle_count, 1);
    do_write(84, 7);
    check("t1_pass", pass, 1);
    check("t1_done", done, 1);
    check("t1_code", fail_code, 0);
    check("t1_mc", match_count, 1);
    check("t1_cyc", cycle_count, 2);
    idle_cycles(2);
    check("t1_hold", pass, 1);

    // 2: unexpected address
    start_run(1);
    check("t2_restart_mc", match_count, 0);
    do_write(88, 5);
    check("t2_code", fail_code, 1);
    check("t2_addr", fail_addr, 88);
    check("t2_data", fail_data, 5);
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);

    // 3: data mismatch
    start_run(1);
    check("t3_clr_code", fail_code, 0);
    check("t3_clr_addr", fail_addr, 0);
    do_write(84, 6);
    check("t3_code", fail_code, 2);
    check("t3_addr", fail_addr, 84);
    check("t3_data", fail_data, 6);

    // 4: timeout, and a completing write on the last cycle wins
    start_run(1);
    idle_cycles(TMO - 1);
    check("t4_pre_busy", busy, 1);
    check("t4_pre_cyc", cycle_count, TMO - 1);
    idle_cycles(1);
    check("t4_code", fail_code, 3);
    check("t4_cyc", cycle_count, TMO);
    check("t4_faddr", fail_addr, 0);
    check("t4_done", done, 1);
    start_run(1);
    idle_cycles(TMO - 1);
    do_write(84, 7);
    check("t4_late_pass", pass, 1);
    check("t4_late_cyc", cycle_count, TMO);

    // 5: out-of-order pair
    cfg_entry(1, 88, 9);
    start_run(2);
    do_write(88, 9);
`ifdef MWC_OUT_OF_ORDER_EN
    check("t5_ooo_busy", busy, 1);
    check("t5_ooo_mc1", match_count, 1);
    do_write(84, 7);
    check("t5_ooo_pass", pass, 1);
    check("t5_ooo_mc2", match_count, 2);
`else
    check("t5_code", fail_code, 1);
    check("t5_addr", fail_addr, 88);
    check("t5_data", fail_data, 9);
`endif

    // cfg_num clamped to DEPTH, cfg_we and start ignored while running
    cfg_entry(2, 92, 1);
    cfg_entry(3, 96, 2);
    start_run(7);
    do_write(84, 7);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_addr = 32'd88; cfg_data = 32'd100;
    start = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; start = 1'b0;
    check("clamp_mc1", match_count, 1);
    check("clamp_busy", busy, 1);
    do_write(88, 9);
    do_write(92, 1);
    check("clamp_busy3", busy, 1);
    do_write(96, 2);
    check("clamp_pass", pass, 1);
    check("clamp_mc", match_count, 4);

    // 6: asynchronous reset mid-run
    start_run(2);
    do_write(84, 7);
    check("t6_mc_pre", match_count, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_mc", match_count, 0);
    check("t6_cyc", cycle_count, 0);
    check("t6_code", fail_code, 0);
    @(negedge clk);
    reset = 1'b1;
    start_run(0);
    check("t6_zero_pass", pass, 1);
    check("t6_zero_busy", busy, 0);
    // table was cleared, so entry 0 now expects (0,0)
    start_run(1);
    do_write(0, 0);
    check("t6_tbl_clear_pass", pass, 1);
    check("t6_tbl_clear_mc", match_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=expired expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
